// File: rtl/fir_decim_fifo.sv
// fir_decim_fifo: decimates FIR output samples by 2**DECIM_LOG2 and buffers the kept ones in a show-ahead FIFO.
// Define DECIM_AVG_EN to replace pick-every-Nth decimation with a boxcar average of each group of samples.
module fir_decim_fifo #(
    parameter int DECIM_LOG2 = 2,
    parameter int DEPTH_LOG2 = 4,
    parameter int DW         = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DW-1:0]         in_data,
    input  logic                  in_valid,
    input  logic                  sync_in,
    output logic [DW-1:0]         out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DEPTH_LOG2:0]   fifo_level,
    output logic                  overflow,
    input  logic                  ovf_clr
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] LEVEL_FULL = (DEPTH_LOG2+1)'(DEPTH);

    logic [DECIM_LOG2-1:0] phase_q, phase_d, curPhase;
    logic                  keep;
    logic [DW-1:0]         keepData;

    // sync_in forces the current sample to phase 0; the counter only moves on valid samples
    always_comb begin
        curPhase = sync_in ? '0 : phase_q;
        phase_d  = in_valid ? curPhase + DECIM_LOG2'(1) : phase_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

`ifdef DECIM_AVG_EN
    localparam int AW = DW + DECIM_LOG2;

    logic signed [AW-1:0] acc_q, acc_d, sum, avg;

    // Accumulator restarts on sync; the last sample of a group is folded in before the shift
    always_comb begin
        sum      = (sync_in ? '0 : acc_q) + {{DECIM_LOG2{in_data[DW-1]}}, in_data};
        avg      = sum >>> DECIM_LOG2;
        keep     = in_valid && (&curPhase);
        keepData = avg[DW-1:0];
        acc_d    = acc_q;
        if (in_valid) begin
            acc_d = keep ? '0 : sum;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    always_comb begin
        keep     = in_valid && (curPhase == '0);
        keepData = in_data;
    end
`endif

    logic [DW-1:0]         mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr_q, rdPtr_q;
    logic [DEPTH_LOG2:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  full, pop, push, drop;

    // A full FIFO still accepts a push when the head is leaving on the same edge
    always_comb begin
        full       = (level_q == LEVEL_FULL);
        pop        = (level_q != '0) && out_ready;
        push       = keep && (!full || pop);
        drop       = keep && full && !pop;
        level_d    = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(pop);
        overflow_d = drop | (overflow_q & ~ovf_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_q + DEPTH_LOG2'(push);
            rdPtr_q    <= rdPtr_q + DEPTH_LOG2'(pop);
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wrPtr_q] <= keepData;
        end
    end

    assign out_data   = mem_q[rdPtr_q];
    assign out_valid  = (level_q != '0);
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// tb_fir_decim_fifo: table vectors, directed corner sequences and random traffic against a queue-based model.
// Expectations follow DECIM_AVG_EN when it is defined.
module tb_fir_decim_fifo;

    localparam int DECIM_LOG2 = 2;
    localparam int DEPTH_LOG2 = 4;
    localparam int DW         = 16;
    localparam int DECIM      = 1 << DECIM_LOG2;
    localparam int DEPTH      = 1 << DEPTH_LOG2;
`ifdef DECIM_AVG_EN
    localparam int KEEP_PHASE = DECIM - 1;
    localparam int AVG_OFF    = 1;
`else
    localparam int KEEP_PHASE = 0;
    localparam int AVG_OFF    = 0;
`endif

    logic                clk;
    logic                reset;
    logic [DW-1:0]       in_data;
    logic                in_valid;
    logic                sync_in;
    logic [DW-1:0]       out_data;
    logic                out_valid;
    logic                out_ready;
    logic [DEPTH_LOG2:0] fifo_level;
    logic                overflow;
    logic                ovf_clr;

    fir_decim_fifo #(.DECIM_LOG2(DECIM_LOG2), .DEPTH_LOG2(DEPTH_LOG2), .DW(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .sync_in   (sync_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_level(fifo_level),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: sample counter, running group sum, queue of buffered samples
    int            mPhase = 0;
    int            mAcc   = 0;
    logic [DW-1:0] mq[$];
    logic          mOvf   = 1'b0;
    logic [DW-1:0] dutPops[$];

    typedef struct {
        logic        rst;
        logic        vld;
        logic [15:0] data;
        logic        sync;
        logic        rdy;
        logic        clr;
        logic        eValid;
        int          eLevel;
        logic        eOvf;
        logic [15:0] eData;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic modelStep(input logic r, input logic v, input logic [DW-1:0] d,
                             input logic s, input logic rdy, input logic clr);
        logic          doPop;
        logic          doPush;
        logic          doDrop;
        logic [DW-1:0] val;
        int            q;
        if (r) begin
            mPhase = 0;
            mAcc   = 0;
            mq.delete();
            mOvf   = 1'b0;
            return;
        end
        doPop  = (mq.size() != 0) && rdy;
        doPush = 1'b0;
        val    = '0;
        if (v) begin
            if (s) begin
                mPhase = 0;
                mAcc   = 0;
            end
`ifdef DECIM_AVG_EN
            mAcc = mAcc + int'($signed(d));
            if (mPhase == DECIM - 1) begin
                q = mAcc / DECIM;
                if ((mAcc % DECIM != 0) && (mAcc < 0)) q = q - 1;
                val    = DW'(q);
                doPush = 1'b1;
                mAcc   = 0;
            end
`else
            q = 0;
            if (mPhase == 0) begin
                val    = d;
                doPush = 1'b1;
            end
`endif
            mPhase = (mPhase + 1) % DECIM;
        end
        doDrop = doPush && (mq.size() == DEPTH) && !doPop;
        if (doPop) void'(mq.pop_front());
        if (doPush && !doDrop) mq.push_back(val);
        mOvf = doDrop ? 1'b1 : (clr ? 1'b0 : mOvf);
    endtask

    task automatic checkOutput();
        check("out_valid", int'(out_valid), int'(mq.size() != 0));
        check("fifo_level", int'(fifo_level), mq.size());
        check("overflow", int'(overflow), int'(mOvf));
        if (mq.size() != 0) check("out_data", int'(out_data), int'(mq[0]));
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [DW-1:0] d,
                                 input logic s, input logic rdy, input logic clr);
        @(negedge clk);
        reset     = r;
        in_valid  = v;
        in_data   = d;
        sync_in   = s;
        out_ready = rdy;
        ovf_clr   = clr;
        if (!r && out_valid && rdy) dutPops.push_back(out_data);
        @(posedge clk);
        modelStep(r, v, d, s, rdy, clr);
        #1;
        checkOutput();
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int            nLoop;
        logic [DW-1:0] expSeq[$];
        reset = 1'b1; in_valid = 1'b0; in_data = '0; sync_in = 1'b0; out_ready = 1'b0; ovf_clr = 1'b0;

`ifdef DECIM_AVG_EN
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'd1,    1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'd2,    1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'd3,    1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'd6,    1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 16'd3});
        vecs.push_back('{1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 16'hFFFE});
        vecs.push_back('{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 16'h7FFF});
`else
        vecs.push_back('{1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 16'h0000});
        vecs.push_back('{1'b0, 1'b1, 16'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd1,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd2,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd3,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd4,  1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 16'd4});
        vecs.push_back('{1'b0, 1'b1, 16'd5,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd6,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd7,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd8,  1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 16'd8});
        vecs.push_back('{1'b0, 1'b1, 16'd9,  1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd10, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd11, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1, 1'b0, 16'd12});
        vecs.push_back('{1'b0, 1'b1, 16'd13, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd14, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
        vecs.push_back('{1'b0, 1'b1, 16'd15, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 16'd0});
`endif

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].vld, vecs[i].data, vecs[i].sync, vecs[i].rdy, vecs[i].clr);
            check("vec_valid", int'(out_valid), int'(vecs[i].eValid));
            check("vec_level", int'(fifo_level), vecs[i].eLevel);
            check("vec_overflow", int'(overflow), int'(vecs[i].eOvf));
            if (vecs[i].eValid) check("vec_data", int'(out_data), int'(vecs[i].eData));
        end

        // Backpressure: 80 samples with the consumer stalled, then drain
        applyStimulus(1, 0, 0, 0, 0, 0);
        dutPops.delete();
        for (int i = 0; i < 80; i++) applyStimulus(0, 1, DW'(i), 0, 0, 0);
        check("bp_level_full", int'(fifo_level), DEPTH);
        check("bp_overflow_set", int'(overflow), 1);
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        check("bp_drain_count", dutPops.size(), DEPTH);
        for (int k = 0; k < DEPTH && k < dutPops.size(); k++)
            check("bp_drain_order", int'(dutPops[k]), 4 * k + AVG_OFF);
        applyStimulus(0, 0, 0, 0, 0, 1);
        check("bp_overflow_clr", int'(overflow), 0);

        // Full FIFO with simultaneous push and pop
        dutPops.delete();
        for (int n = 0; n < 200 && mq.size() < DEPTH; n++) applyStimulus(0, 1, DW'($urandom), 0, 0, 0);
        nLoop = 0;
        while (mPhase != KEEP_PHASE && nLoop < 2 * DECIM) begin
            applyStimulus(0, 1, 16'h1234, 0, 0, 0);
            nLoop++;
        end
        check("full_level_before", int'(fifo_level), DEPTH);
        applyStimulus(0, 1, 16'h1234, 0, 1, 0);
        check("full_pushpop_level", int'(fifo_level), DEPTH);
        check("full_pushpop_ovf", int'(overflow), 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 1, 0);
        check("full_pushpop_count", dutPops.size(), DEPTH + 1);
        if (dutPops.size() != 0) check("full_pushpop_last", int'(dutPops[dutPops.size() - 1]), 16'h1234);

        // Input gaps and phase realign on sample 6
        applyStimulus(1, 0, 0, 0, 0, 0);
        dutPops.delete();
        for (int v = 0; v < 16; v++) begin
            for (int g = 0; g < int'($urandom_range(1, 3)); g++) applyStimulus(0, 0, 16'hDEAD, 0, 1, 0);
            applyStimulus(0, 1, DW'(v), v == 6, 1, 0);
        end
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1, 0);
`ifdef DECIM_AVG_EN
        expSeq = '{16'd1, 16'd7, 16'd11};
`else
        expSeq = '{16'd0, 16'd4, 16'd6, 16'd10, 16'd14};
`endif
        check("sync_count", dutPops.size(), expSeq.size());
        for (int k = 0; k < expSeq.size() && k < dutPops.size(); k++)
            check("sync_order", int'(dutPops[k]), int'(expSeq[k]));

        // Reset while the FIFO holds 5 entries
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5 * DECIM; i++) applyStimulus(0, 1, DW'(100 + i), 0, 0, 0);
        check("rst_level_before", int'(fifo_level), 5);
        applyStimulus(1, 1, 16'h5555, 0, 0, 0);
        check("rst_valid", int'(out_valid), 0);
        check("rst_level", int'(fifo_level), 0);
        for (int i = 0; i < DECIM; i++) applyStimulus(0, 1, 16'h0ABC, 0, 0, 0);
        check("rst_first_level", int'(fifo_level), 1);
        check("rst_first_data", int'(out_data), 16'h0ABC);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom % 500) == 0, ($urandom % 5) != 0, DW'($urandom),
                          ($urandom % 16) == 0, ($urandom % 4) == 0, ($urandom % 32) == 0);
        end

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
Downstream stage of the 51-tap FIR filter. Consumes the filter's 16-bit signed output samples, each qualified by a valid strobe, and decimates them by a power-of-two factor. Buffers the kept samples in a show-ahead FIFO and presents them to the next consumer over a valid/ready handshake. Reports FIFO occupancy and a sticky overflow flag for the control/status logic.

Parameters:
DECIM_LOG2, 2, decimation factor DECIM = 2**DECIM_LOG2; legal range 1..6
DEPTH_LOG2, 4, FIFO depth = 2**DEPTH_LOG2 entries; legal range 2..8
DW, 16, sample width, two's-complement signed

Ports:
clk  in  1  clock; all logic on rising edge
reset  in  1  synchronous reset, active-high
in_data  in  DW  filtered sample from the FIR output
in_valid  in  1  in_data is valid this cycle; no backpressure to the FIR
sync_in  in  1  phase realign; only honoured when in_valid=1
out_data  out  DW  FIFO head sample
out_valid  out  1  FIFO not empty
out_ready  in  1  consumer accepts out_data this cycle
fifo_level  out  DEPTH_LOG2+1  entries currently held
overflow  out  1  sticky: a kept sample was dropped because the FIFO was full
ovf_clr  in  1  clears overflow

Behaviour:
- Design: one clock, clk. Reset is synchronous and active-high. The reset port is named reset.
- Reset: phase counter=0, accumulator=0, FIFO pointers=0, fifo_level=0, out_valid=0, overflow=0. out_data is don't-care while out_valid=0.
- Reset mid-operation: all FIFO contents are discarded. On the cycle after reset is sampled, out_valid=0 and fifo_level=0.
- Phase counter: DECIM_LOG2 bits wide. It advances only when in_valid=1 and wraps from DECIM-1 to 0. It holds during in_valid gaps.
- sync_in with in_valid: the current sample is treated as phase 0, and the next phase is 1.
- Pick mode (default): a sample is kept when its phase is 0.
- Push: a kept sample is written to the FIFO on the same edge it is accepted.
- Latency: when the FIFO is empty, out_valid rises the cycle after the edge that accepts the kept sample.
- out_data: driven from the FIFO head (show-ahead). It is stable while out_valid=1 and out_ready=0.
- Pop: occurs when out_valid=1 and out_ready=1. out_ready while empty is ignored.
- Full, push only: the new sample is dropped, overflow is set, and contents and level are unchanged.
- Full, simultaneous push and pop: both are performed. The level stays at DEPTH, and overflow is not set.
- Empty, push: out_data equals the pushed sample on the next cycle. There is no bypass in the same cycle.
- fifo_level: computed as level + push - pop, updated every edge.
- ovf_clr: clears overflow on the next edge. If ovf_clr and a new overflow event occur in the same cycle, overflow ends up set.
- Ordering: FIFO output order equals acceptance order. No sample is duplicated.
- Pointers: DEPTH_LOG2 bits, naturally wrapping. Full/empty is derived from fifo_level.

Optional Feature:
Macro: DECIM_AVG_EN
- Defined: boxcar-average mode replaces pick mode.
  - Accumulator is DW+DECIM_LOG2 bits, signed; in_data is sign-extended before adding.
  - At phase DECIM-1, the value (acc + in_data) >>> DECIM_LOG2 is pushed. This is an arithmetic shift, so rounding is toward minus infinity. The accumulator then clears.
  - sync_in restarts accumulation with the current sample as the first term, discarding the partial sum. Because the current sample is phase 0, no push occurs on that cycle.
  - Reset clears the accumulator.
  - Push/overflow rules are identical to pick mode.
- Undefined: no accumulator is instantiated, and the behaviour is pick mode exactly.

Test Plan:
1. Pick mode, DECIM_LOG2=2: reset, then drive in_data=0..15 with in_valid=1 every cycle and out_ready=1. Expect the output sequence 0,4,8,12. Each out_valid pulse comes one cycle after the accepting edge. Expect no overflow.
2. Backpressure, DEPTH_LOG2=4: hold out_ready=0 and drive 80 samples (20 kept). Expect fifo_level=16 and overflow=1. Then raise out_ready. Expect the drained sequence to be kept samples #0..#15, in order: 0,4,…,60. Pulse ovf_clr and expect overflow=0.
3. Full plus simultaneous push and pop: with level=16, push a kept sample while out_ready=1. Expect level to stay 16, overflow to stay 0, and the new sample to appear last in the drained order.
4. Gaps and realign: insert in_valid=0 gaps of 1–3 cycles. Expect the kept samples to be unchanged. Assert sync_in with sample value 6. Expect the kept sequence …,4,6,10,14.
5. Reset mid-operation: with level=5, assert reset for one cycle. Expect out_valid=0 and fifo_level=0 the next cycle. After release, the next kept sample is the first input.
6. DECIM_AVG_EN, DECIM_LOG2=2: input 1,2,3,6 gives output 3. Input -1,-2,-2,-2 (sum -7) gives output -2. Input 0x7FFF×4 gives output 0x7FFF.
